uncached_store_buffer: RTL and testbench
========================================

Name: uncached_store_buffer

Overview:
- Parametrised write-posting buffer for the uncached region (0xA000_0000–0xBFFF_FFFF) of the MEM stage.
- Stores are accepted in one cycle and drained in order over the SRAM-like data bus (req / addr_ok / data_ok). MEM does not stall on uncached stores unless the buffer is full.
- Uncached loads are strongly ordered: the buffer fully drains before a load issues. Loads never forward from the buffer, because MMIO is not forwardable.
- Replaces the single-outstanding blocking uncached path.

Parameters:
- DEPTH, 4, number of posted-store entries (≥1, any value, not restricted to powers of two)
- ADDR_W, 32, address width
- DATA_W, 32, data width; STRB_W = DATA_W/8 byte lanes

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  uncached store from MEM; exception and misalignment already filtered upstream
- st_addr  in  ADDR_W  store address
- st_wdata  in  DATA_W  lane-aligned store data
- st_strb  in  STRB_W  byte enables (calWE)
- st_ready  out  1  store accepted this cycle
- ld_valid  in  1  uncached load request, held until ld_done or flush
- ld_addr  in  ADDR_W  load address
- ld_size  in  3  log2 bytes of the load
- ld_done  out  1  one-cycle pulse; ld_rdata valid
- ld_rdata  out  DATA_W  registered load data, held until the next ld_done
- flush  in  1  pipeline flush; cancels a load not yet address-accepted
- stall  out  1  (ld_valid & ~ld_done) | (st_valid & ~st_ready)
- empty  out  1  no stores pending and bus idle
- mem_req  out  1  bus request
- mem_wr  out  1  1 = write
- mem_size  out  3  log2 bytes
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_rdata  in  DATA_W  bus read data
- mem_addr_ok  in  1  address handshake
- mem_data_ok  in  1  data handshake

Behaviour:
- Reset values: FIFO empty (count=0, rd_ptr=wr_ptr=0); state IDLE. Outputs: mem_req=0, mem_wr=0, mem_size=0, mem_addr=0, mem_wdata=0, ld_done=0, ld_rdata=0, st_ready=1, empty=1.
- Reset mid-transaction: the outstanding transaction is abandoned. The bus bridge shares the same rst.
- Store push:
  - st_ready = (count<DEPTH) | pop_this_cycle, where pop_this_cycle = W_DATA & mem_data_ok. Simultaneous push and pop at full is accepted and count is unchanged.
  - On st_valid & st_ready, {addr,data,strb} is written at wr_ptr on the clock edge.
  - Pointers wrap from DEPTH-1 to 0.
- If st_valid and ld_valid are both asserted, the store is pushed first and the load waits. MEM never legally does this; the precedence is defined anyway.
- mem_size is derived from the head strb: 1 lane → 0, 2 lanes → 1, 4 lanes → 2 (generally log2 of popcount). Non-contiguous strb is illegal and flagged by an assertion.
- mem_addr for writes = head addr. The low bits are kept intact and the bridge uses them.
- FSM:
  - IDLE: if count>0 → W_ADDR. Else if ld_valid & ~flush & ~ld_done_q → R_ADDR.
  - W_ADDR: mem_req=1, mem_wr=1, address/data/size from the FIFO head, stable until mem_addr_ok. On mem_addr_ok → W_DATA.
  - W_DATA: mem_req=0. On mem_data_ok: pop the head. Then if count_next>0 → W_ADDR (back-to-back, req next cycle); else if ld_valid pending → R_ADDR; else → IDLE.
  - R_ADDR: mem_req=1, mem_wr=0, mem_addr=ld_addr, mem_size=ld_size. If flush is asserted before mem_addr_ok → IDLE with no bus side effect. On mem_addr_ok → R_DATA.
  - R_DATA: on mem_data_ok, ld_rdata<=mem_rdata, ld_done pulses 1 cycle, → IDLE. If flush arrived while in R_DATA, the response is still consumed, but ld_done is suppressed and ld_rdata is unchanged.
- ld_done_q: one-cycle guard so that the still-high ld_valid on the ld_done cycle does not re-issue the same load.
- Latency:
  - Store: mem_req is asserted the cycle after the push at the earliest.
  - Load with an empty buffer: mem_req is asserted the cycle after ld_valid; ld_done comes the cycle after mem_data_ok.
- Only one bus transaction is outstanding at a time. The data-phase channel ignores mem_data_ok outside W_DATA/R_DATA.
- empty = (count==0) & (state==IDLE). Used by SYNC/ERET drain logic.

Decomposition:
- Package usb_pkg:
  - state enum {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA}
  - function strb_to_size
  - SIZE_W=3
- Sub-module sb_fifo: generic synchronous FIFO (DEPTH, WIDTH) with push/pop/full/empty/count and head output. Stores the packed {addr,data,strb} entry.

Test Plan:
- Single store addr=0xBFD0_F000 data=0x1234_5678 strb=4'b1111, addr_ok/data_ok 1-cycle response → one write, mem_size=2, empty=1 two cycles after data_ok; no stall.
- Push 5 stores with DEPTH=4 and the bus stalled (addr_ok=0) → st_ready=0 on the 5th store, stall=1. Release the bus → the 5th store is accepted on the first pop cycle; 5 writes are issued in order, and pointer wrap is exercised.
- 2 stores pending, then a load at addr 0xBFD0_F000 → the read req appears only after the second write's data_ok; ld_done pulses with ld_rdata=mem_rdata=0xCAFE_F00D.
- Byte store strb=4'b0100 → mem_size=0, mem_addr unchanged, mem_wdata[23:16] carries the byte. Half store strb=4'b1100 → mem_size=1.
- Load with flush asserted in R_ADDR before addr_ok → mem_req drops, no ld_done. Flush in R_DATA → response consumed, ld_done=0, ld_rdata keeps its old value.
- rst asserted in W_DATA with 3 entries queued → next cycle count=0, mem_req=0, st_ready=1, empty=1.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and helpers for the uncached store buffer.
// Bus size encoding is log2 of the number of enabled byte lanes.
package usb_pkg;

  localparam int SIZE_W   = 3;
  localparam int MAX_STRB = 16;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    R_DATA
  } state_t;

  function automatic logic [SIZE_W-1:0] strb_to_size(
    input logic [MAX_STRB-1:0] s
  );
    int n;
    n = 0;
    for (int i = 0; i < MAX_STRB; i++) n += int'(s[i]);
    strb_to_size = '0;
    for (int i = 1; i <= 4; i++)
      if (n >= (1 << i)) strb_to_size = SIZE_W'(i);
  endfunction

  // Legal: non-empty, one contiguous run, power-of-two lanes.
  function automatic logic strb_legal(
    input logic [MAX_STRB-1:0] s
  );
    int n;
    int lo;
    int hi;
    n  = 0;
    lo = -1;
    hi = -1;
    for (int i = 0; i < MAX_STRB; i++) begin
      if (s[i]) begin
        n++;
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    strb_legal = (n != 0) && (hi - lo + 1 == n) &&
                 ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uncached_store_buffer_fifo.sv
// Generic synchronous FIFO holding posted store entries.
// Push while full is accepted only when a pop happens the same cycle.
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    nxt = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uncached_store_buffer.sv
// Posted-write buffer for the uncached region with strongly
// ordered loads; one bus transaction outstanding at a time.
module uncached_store_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic [STRB_W-1:0] st_strb,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [SIZE_W-1:0] ld_size,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              flush,
  output logic              stall,
  output logic              empty,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } entry_t;

  entry_t            st_ent;
  entry_t            head;
  logic [CW-1:0]     cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              more;
  state_t            state;
  logic              ld_done_q;
  logic              kill_q;
  logic [DATA_W-1:0] rdata_q;

  assign st_ent   = '{addr: st_addr, data: st_wdata, strb: st_strb};
  assign pop      = (state == W_DATA) & mem_data_ok;
  assign st_ready = ~fifo_full | pop;
  assign push     = st_valid & st_ready;
  assign more     = (cnt > CW'(1)) | push;

  sb_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(st_ent),
    .pop  (pop),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ld_done_q <= 1'b0;
      kill_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ld_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty || push)
            state <= W_ADDR;
          else if (ld_valid && !flush && !ld_done_q)
            state <= R_ADDR;
        end
        W_ADDR: begin
          if (mem_addr_ok) state <= W_DATA;
        end
        W_DATA: begin
          if (mem_data_ok) begin
            if (more)
              state <= W_ADDR;
            else if (ld_valid && !flush)
              state <= R_ADDR;
            else
              state <= IDLE;
          end
        end
        R_ADDR: begin
          kill_q <= 1'b0;
          if (flush)
            state <= IDLE;
          else if (mem_addr_ok)
            state <= R_DATA;
        end
        R_DATA: begin
          if (mem_data_ok) begin
            state  <= IDLE;
            kill_q <= 1'b0;
            if (!(kill_q || flush)) begin
              ld_done_q <= 1'b1;
              rdata_q   <= mem_rdata;
            end
          end else if (flush) begin
            kill_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush masks the read request so a cancelled load never reaches the bus.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      state == W_ADDR: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = strb_to_size(MAX_STRB'(head.strb));
        mem_addr  = head.addr;
        mem_wdata = head.data;
      end
      state == R_ADDR: begin
        mem_req  = ~flush;
        mem_size = ld_size;
        mem_addr = ld_addr;
      end
      default: ;
    endcase
  end

  assign ld_done  = ld_done_q;
  assign ld_rdata = rdata_q;
  assign empty    = fifo_empty & (state == IDLE);
  assign stall    = (ld_valid & ~ld_done) | (st_valid & ~st_ready);

  a_strb_legal: assert property (
    @(posedge clk) disable iff (rst)
    push |-> strb_legal(MAX_STRB'(st_strb))
  );

endmodule

// File: tb/tb_uncached_store_buffer.sv
// Self-checking bench: table-driven stores, scoreboarded bus
// transactions, and hand sequences for stall, flush and reset.
module tb_uncached_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_size;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        flush;
  logic        stall;
  logic        empty;
  logic        mem_req;
  logic        mem_wr;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  uncached_store_buffer #(
    .DEPTH(4),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .st_strb    (st_strb),
    .st_ready   (st_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_size    (ld_size),
    .ld_done    (ld_done),
    .ld_rdata   (ld_rdata),
    .flush      (flush),
    .stall      (stall),
    .empty      (empty),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic        wr;
  } sb_item_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } vec_t;

  sb_item_t    sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        bus_go = 1'b1;
  int          data_wait = 1;
  int          pend_cnt = 0;
  logic [31:0] rd_val = '0;
  logic        acc_stall;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Bus slave: accepts requests when bus_go, answers data after data_wait.
  initial begin
    sb_item_t e;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = rd_val;
        end
      end else if (bus_go && mem_req) begin
        mem_addr_ok = 1'b1;
        pend_cnt    = data_wait;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got request at %h, required none",
                   mem_addr);
        end else begin
          e = sb.pop_front();
          chk("bus_addr", 64'(mem_addr), 64'(e.addr));
          chk("bus_wr", 64'(mem_wr), 64'(e.wr));
          chk("bus_size", 64'(mem_size), 64'(e.size));
          if (e.wr) chk("bus_wdata", 64'(mem_wdata), 64'(e.data));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] sz);
    int n;
    sb_item_t e;
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_strb  = s;
    #2;
    n = 0;
    while (!st_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!st_ready) chk("push_timeout", 64'(st_ready), 64'd1);
    acc_stall = stall;
    e.addr = a;
    e.data = d;
    e.size = sz;
    e.wr   = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      #2;
      n++;
      done = empty && (sb.size() == 0) && (pend_cnt == 0);
    end
    chk(name, 64'(done), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    sb_item_t e;
    int       n;
    logic     seen;

    vecs[0] = '{32'hBFD0_0002, 32'h00AB_0000, 4'b0100, 3'd0};
    vecs[1] = '{32'hBFD0_0002, 32'hBEEF_0000, 4'b1100, 3'd1};
    vecs[2] = '{32'hA000_0001, 32'h0000_5A00, 4'b0010, 3'd0};
    vecs[3] = '{32'hA000_0000, 32'h0000_1234, 4'b0011, 3'd1};
    vecs[4] = '{32'hBFFF_FFFC, 32'hDEAD_BEEF, 4'b1111, 3'd2};
    vecs[5] = '{32'hA000_0007, 32'h7700_0000, 4'b1000, 3'd0};

    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_wdata = '0;
    st_strb  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_size  = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_wr", {mem_req, mem_wr}, 2'b00);
    chk("rst_addr_size", {mem_addr, mem_size}, '0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_ld", {ld_done, ld_rdata}, '0);
    chk("rst_ready_empty", {st_ready, empty}, 2'b11);
    @(negedge clk);
    rst = 1'b0;

    // Single word store, one-cycle bus response.
    push_store(32'hBFD0_F000, 32'h1234_5678, 4'b1111, 3'd2);
    chk("t1_no_stall", 64'(acc_stall), 64'd0);
    #2;
    chk("t1_req_next_cycle", {mem_req, mem_wr, empty}, 3'b110);
    chk("t1_size", 64'(mem_size), 64'd2);
    @(negedge clk);
    #2;
    chk("t1_data_ok", 64'(mem_data_ok), 64'd1);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_sb_drained", 64'(sb.size()), 64'd0);

    // Table of byte/half/word stores.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      push_store(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].size);
      wait_empty($sformatf("vec%0d_drain", i));
    end

    // Five stores into a four-deep buffer with the bus stalled.
    @(negedge clk);
    bus_go = 1'b0;
    for (int i = 0; i < 4; i++)
      push_store(32'hA000_0100 + 32'(i * 4), 32'h1111_0000 + 32'(i),
                 4'b1111, 3'd2);
    st_valid = 1'b1;
    st_addr  = 32'hA000_0110;
    st_wdata = 32'h1111_0004;
    st_strb  = 4'b1111;
    #2;
    chk("full_st_ready", 64'(st_ready), 64'd0);
    chk("full_stall", 64'(stall), 64'd1);
    bus_go = 1'b1;
    n = 0;
    while (!st_ready && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("full_accept_on_pop", {st_ready, mem_data_ok}, 2'b11);
    e = '{32'hA000_0110, 32'h1111_0004, 3'd2, 1'b1};
    sb.push_back(e);
    @(negedge clk);
    st_valid = 1'b0;
    wait_empty("full_drain");

    // Load behind two posted stores.
    @(negedge clk);
    bus_go = 1'b0;
    rd_val = 32'hCAFE_F00D;
    push_store(32'hBFD0_F004, 32'h0000_00A5, 4'b0001, 3'd0);
    push_store(32'hBFD0_F008, 32'h0000_5A5A, 4'b0011, 3'd1);
    ld_valid = 1'b1;
    ld_addr  = 32'hBFD0_F000;
    ld_size  = 3'd2;
    e = '{32'hBFD0_F000, 32'h0, 3'd2, 1'b0};
    sb.push_back(e);
    #2;
    chk("ld_stall", 64'(stall), 64'd1);
    bus_go = 1'b1;
    n = 0;
    while (!ld_done && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("ld_done", 64'(ld_done), 64'd1);
    chk("ld_rdata", 64'(ld_rdata), 64'hCAFE_F00D);
    @(negedge clk);
    ld_valid = 1'b0;
    #2;
    chk("ld_pulse_no_reissue", {ld_done, mem_req}, 2'b00);
    wait_empty("ld_drain");

    // Flush while the read address is pending.
    @(negedge clk);
    bus_go   = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'hA000_0010;
    ld_size  = 3'd0;
    @(negedge clk);
    #2;
    chk("fa_req", {mem_req, mem_wr}, 2'b10);
    chk("fa_addr", 64'(mem_addr), 64'hA000_0010);
    flush = 1'b1;
    #1;
    chk("fa_req_drop", 64'(mem_req), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    ld_valid = 1'b0;
    bus_go   = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #2;
      if (ld_done || mem_req) seen = 1'b1;
    end
    chk("fa_quiet", 64'(seen), 64'd0);
    chk("fa_empty", 64'(empty), 64'd1);

    // Flush after the read address was accepted.
    @(negedge clk);
    data_wait = 2;
    rd_val    = 32'h1111_2222;
    e = '{32'hA000_0020, 32'h0, 3'd2, 1'b0};
    sb.push_back(e);
    ld_valid = 1'b1;
    ld_addr  = 32'hA000_0020;
    ld_size  = 3'd2;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(mem_req && mem_addr_ok) && n < 20);
    chk("fd_handshake", {mem_req, mem_addr_ok}, 2'b11);
    @(negedge clk);
    flush    = 1'b1;
    ld_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    seen  = 1'b0;
    repeat (5) begin
      #2;
      if (ld_done) seen = 1'b1;
      @(negedge clk);
    end
    chk("fd_no_done", 64'(seen), 64'd0);
    chk("fd_rdata_kept", 64'(ld_rdata), 64'hCAFE_F00D);
    wait_empty("fd_drain");
    data_wait = 1;

    // Reset while a write waits for data with three entries queued.
    @(negedge clk);
    data_wait = 20;
    for (int i = 0; i < 3; i++)
      push_store(32'hB000_0000 + 32'(i * 4), 32'h3333_0000 + 32'(i),
                 4'b1111, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #2;
    chk("rr_req", 64'(mem_req), 64'd0);
    chk("rr_ready_empty", {st_ready, empty}, 2'b11);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      #2;
      if (mem_req || !empty) seen = 1'b1;
    end
    chk("rr_abandoned", 64'(seen), 64'd0);
    data_wait = 1;
    @(negedge clk);
    push_store(32'hA000_0200, 32'h4444_5555, 4'b1111, 3'd2);
    wait_empty("rr_fresh_store");

    repeat (3) @(negedge clk);
    chk("final_sb", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
